mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter that acts as the responder on the single-cycle core's data bus (Dw* signals). The core's stores push bytes into an internal FIFO, and its loads read status and control. The block serializes the bytes as 8N1 frames on `oTX`. It raises an interrupt line, intended for one bit of the core's pending-interrupt vector, when the FIFO drains.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hFF20_0110: word-aligned base of the 3-word register window.
- `CLKS_PER_BIT`, default 434: iCLK cycles per serial bit (50 MHz / 115200). Minimum 2.
- `FIFO_DEPTH`, default 8: TX FIFO entries. Must be a power of 2.

Ports:
- `iCLK`, in, 1: clock.
- `iRST`, in, 1: reset, asynchronous, active-high.
- `iReadEnable`, in, 1: bus read strobe (DwReadEnable).
- `iWriteEnable`, in, 1: bus write strobe (DwWriteEnable).
- `iByteEnable`, in, 4: byte lanes (DwByteEnable).
- `iAddress`, in, 32: byte address (DwAddress).
- `iWriteData`, in, 32: store data (DwWriteData).
- `oReadData`, out, 32: load data. 0 when not selected.
- `oHit`, out, 1: address falls in the window; the system read mux uses it.
- `oTX`, out, 1: serial line, idle high.
- `oIRQ`, out, 1: interrupt request, level.

## Operation
- Select: `oHit = (iAddress[31:4] == BASE_ADDR[31:4]) && (iAddress[3:2] != 2'b11)`. Bits [1:0] are ignored.
- Register map, by word offset:
  - 0x0 TXDATA.
    - Write with `iByteEnable[0]=1` pushes `iWriteData[7:0]`.
    - A write with `iByteEnable[0]=0` is ignored.
    - Reads return 0.
  - 0x4 STATUS (read): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[11:8] FIFO count, all other bits 0.
    - Writing 1 to bit3 clears overflow (W1C). All other writes are ignored.
  - 0x8 CTRL (R/W, byte lane 0): bit0 TXEN, bit1 IRQEN. Other bits read 0.
- A push while full with no pop that cycle drops the byte and sets overflow.
- A push while full with a pop in the same cycle is accepted; the count is unchanged.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when TXEN=1 and the FIFO is not empty. The FIFO pops on that edge and the byte latches into the shift register.
  - START drives 0 for `CLKS_PER_BIT` cycles.
  - DATA drives 8 bits, LSB first, `CLKS_PER_BIT` cycles each. A 3-bit index counts them.
  - STOP drives 1 for `CLKS_PER_BIT` cycles, then returns to IDLE.
- Clearing TXEN mid-frame: the current frame completes, and no new pop occurs.
- `oIRQ = IRQEN && empty && FSM==IDLE`.
- Reset values:
  - FIFO empty, pointers 0, overflow 0.
  - TXEN=0, IRQEN=0.
  - FSM IDLE, baud counter 0.
  - `oTX=1` immediately, even mid-frame.
  - `oIRQ=0`, `oReadData=0` when unselected.

## Timing
- Reads are combinational: `oReadData` is valid in the same cycle as `iAddress`/`iReadEnable`, which the single-cycle core needs. There are no wait states.
- Writes commit on the posedge of iCLK where `iWriteEnable && oHit`.
- Latency from the TXDATA write edge (FIFO was empty, TXEN=1, IDLE):
  - +1 edge: pop, FSM enters START, `oTX` falls.
  - +`10*CLKS_PER_BIT` cycles: FSM returns to IDLE.
- Back-to-back frames: STOP→IDLE→START costs 1 extra IDLE cycle. Frame period is `10*CLKS_PER_BIT + 1`.
- The baud counter runs 0..`CLKS_PER_BIT-1` and reloads to 0 on each bit boundary.
- FIFO pointers are `log2(FIFO_DEPTH)` bits and wrap naturally. The count is `log2(FIFO_DEPTH)+1` bits.
- STATUS reflects the state before the current edge. A read in the same cycle as a write returns the old value.

## Structure
- Shared package `mmio_pkg` holds the offsets `OFF_TXDATA=2'd0`, `OFF_STATUS=2'd1`, `OFF_CTRL=2'd2`, the STATUS/CTRL bit indices, and the FSM state enum `uart_tx_state_t`.
- One sub-module: `sync_fifo`, parameterized on width and depth, with push/pop/full/empty/count and the simultaneous push+pop-when-full rule above.
- Bus decode, registers and the FSM stay in the top module.

## Test plan
Bench uses `CLKS_PER_BIT=4`, `FIFO_DEPTH=8`.
1. Reset, write CTRL=0x1, write TXDATA=0xA5 → `oTX` holds 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. STATUS bit0 is 1 during the frame and 0 after.
2. TXEN=0, write 9 bytes 0x00..0x08 → STATUS = 0x0000080A (count 8, full, overflow). Write STATUS=0x8 → bit3 clears. `oTX` stays 1.
3. CTRL=0x3 with the FIFO empty → `oIRQ=1`. Write TXDATA=0x55 → `oIRQ=0` until the frame completes, then 1.
4. Read at BASE_ADDR+0xC and at BASE_ADDR+0x20 → `oHit=0`, `oReadData=0`. Read at BASE_ADDR+0x8 after writing 0x3 → 0x00000003.
5. Assert `iRST` during DATA bit 3 of a frame → `oTX=1` asynchronously, STATUS=0x4, and no further frames after release.
6. FIFO full with TXEN=1 and a pop on cycle N; push 0x77 on cycle N → no overflow, count stays 8, and 0x77 is transmitted last.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for memory-mapped peripherals on the core's data bus.
// Holds the register word offsets, the STATUS/CTRL bit positions and the
// UART transmit state enum.
package mmio_pkg;

  // Word offsets within a peripheral window (address bits [3:2]).
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  // STATUS bit positions.
  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  // CTRL bit positions.
  localparam int CTRL_TXEN  = 0;
  localparam int CTRL_IRQEN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count.
// Ports: clk/rst (async, active-high); push/wdata write side; pop/rdata
// read side (rdata shows the head entry, valid whenever !empty); full,
// empty, count status; drop pulses when a push is refused (full, no pop).
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // The slot freed by a same-cycle pop makes room for the push.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and a reset-free array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's data bus.
// Ports: iCLK/iRST (async, active-high); iReadEnable, iWriteEnable,
// iByteEnable, iAddress, iWriteData from the core; oReadData (combinational
// load data, 0 when not selected), oHit (address in the 3-word window),
// oTX (serial line, idle high), oIRQ (level, FIFO drained while enabled).
// Registers: +0x0 TXDATA (write pushes byte), +0x4 STATUS (overflow W1C),
// +0x8 CTRL (TXEN, IRQEN).
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFF20_0110,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [3:0]  iByteEnable,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oHit,
  output logic        oTX,
  output logic        oIRQ
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  logic [1:0]     off;
  logic           hit;
  logic           wr_sel;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic           drop;
  logic [7:0]     fifo_rdata;
  logic [CW-1:0]  count;
  logic           txen_q;
  logic           irqen_q;
  logic           ovf_q;
  uart_tx_state_t state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           bit_done;
  logic [31:0]    status_word;
  logic           unused_bits;

  // Byte lanes other than 0 and the low address bits carry nothing here.
  assign unused_bits = ^{iByteEnable[3:1], iAddress[1:0], iWriteData[31:8]};

  // ---------------- bus decode ----------------
  assign off    = iAddress[3:2];
  assign hit    = (iAddress[31:4] == BASE_ADDR[31:4]) && (off != 2'b11);
  assign oHit   = hit;
  assign wr_sel = iWriteEnable && hit;
  assign push   = wr_sel && (off == OFF_TXDATA) && iByteEnable[0];
  assign pop    = (state_q == IDLE) && txen_q && !empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRST),
    .push  (push),
    .pop   (pop),
    .wdata (iWriteData[7:0]),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count),
    .drop  (drop)
  );

  // ---------------- control / status registers ----------------
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      txen_q  <= 1'b0;
      irqen_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (drop)
        ovf_q <= 1'b1;
      else if (wr_sel && (off == OFF_STATUS) && iWriteData[ST_OVF])
        ovf_q <= 1'b0;
      if (wr_sel && (off == OFF_CTRL) && iByteEnable[0]) begin
        txen_q  <= iWriteData[CTRL_TXEN];
        irqen_q <= iWriteData[CTRL_IRQEN];
      end
    end
  end

  // ---------------- transmit FSM ----------------
  assign bit_done = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (state_q != IDLE) baud_d = bit_done ? '0 : baud_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = START;
          baud_d  = '0;
          shreg_d = fifo_rdata;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == 3'd7) state_d = STOP;
          idx_d = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from state so reset forces it high at once.
  always_comb begin
    oTX = 1'b1;
    case (state_q)
      START:   oTX = 1'b0;
      DATA:    oTX = shreg_q[idx_q];
      default: oTX = 1'b1;
    endcase
  end

  assign oIRQ = irqen_q && empty && (state_q == IDLE);

  // ---------------- read path (combinational) ----------------
  always_comb begin
    status_word                           = '0;
    status_word[ST_BUSY]                  = (state_q != IDLE);
    status_word[ST_FULL]                  = full;
    status_word[ST_EMPTY]                 = empty;
    status_word[ST_OVF]                   = ovf_q;
    status_word[ST_COUNT_LSB +: CW]       = count;
  end

  always_comb begin
    oReadData = '0;
    if (iReadEnable && hit) begin
      case (off)
        OFF_STATUS: oReadData = status_word;
        OFF_CTRL:   oReadData = {30'd0, irqen_q, txen_q};
        default:    oReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// A queue-based model predicts line level, IRQ, hit and read data every
// cycle; a small serial receiver decodes frames from oTX independently.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFF20_0110;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iReadEnable  = 1'b0;
  logic        iWriteEnable = 1'b0;
  logic [3:0]  iByteEnable  = 4'h0;
  logic [31:0] iAddress     = 32'h0;
  logic [31:0] iWriteData   = 32'h0;
  logic [31:0] oReadData;
  logic        oHit;
  logic        oTX;
  logic        oIRQ;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 iCLK = ~iCLK;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iReadEnable  (iReadEnable),
    .iWriteEnable (iWriteEnable),
    .iByteEnable  (iByteEnable),
    .iAddress     (iAddress),
    .iWriteData   (iWriteData),
    .oReadData    (oReadData),
    .oHit         (oHit),
    .oTX          (oTX),
    .oIRQ         (oIRQ)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned m_q[$];
  bit           m_ovf     = 1'b0;
  bit           m_txen    = 1'b0;
  bit           m_irqen   = 1'b0;
  bit           m_active  = 1'b0;
  int           m_elapsed = 0;
  byte unsigned m_byte    = 8'h00;

  function automatic bit exp_hit(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + 33'd12));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // A frame is ten equal slots: start(0), data LSB first, stop(1).
  function automatic bit exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_elapsed / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s    = 32'(m_q.size()) << 8;
    s[0] = m_active;
    s[1] = (m_q.size() == DEPTH);
    s[2] = (m_q.size() == 0);
    s[3] = m_ovf;
    return s;
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (!(iReadEnable && exp_hit(iAddress))) return 32'h0;
    case (word_of(iAddress))
      1:       return exp_status();
      2:       return {30'd0, m_irqen, m_txen};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      m_q.delete();
      m_ovf     = 1'b0;
      m_txen    = 1'b0;
      m_irqen   = 1'b0;
      m_active  = 1'b0;
      m_elapsed = 0;
    end else begin
      bit           pop_now;
      byte unsigned popped;
      popped  = 8'h00;
      pop_now = !m_active && m_txen && (m_q.size() != 0);
      if (pop_now) popped = m_q.pop_front();
      if (iWriteEnable && exp_hit(iAddress)) begin
        case (word_of(iAddress))
          0: if (iByteEnable[0]) begin
               if (m_q.size() < DEPTH) m_q.push_back(iWriteData[7:0]);
               else m_ovf = 1'b1;
             end
          1: if (iWriteData[3]) m_ovf = 1'b0;
          2: if (iByteEnable[0]) begin
               m_txen  = iWriteData[0];
               m_irqen = iWriteData[1];
             end
          default: ;
        endcase
      end
      if (m_active) begin
        m_elapsed++;
        if (m_elapsed == 10 * CPB) m_active = 1'b0;
      end
      if (pop_now) begin
        m_active  = 1'b1;
        m_elapsed = 0;
        m_byte    = popped;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge iCLK) begin
    if (cmp_en) begin
      check("cyc_tx",    32'(oTX),  32'(exp_tx()));
      check("cyc_irq",   32'(oIRQ), 32'(m_irqen && (m_q.size() == 0) && !m_active));
      check("cyc_hit",   32'(oHit), 32'(exp_hit(iAddress)));
      check("cyc_rdata", oReadData, exp_rdata());
    end
  end

  // ---------------- independent serial receiver ----------------
  byte unsigned rx_q[$];
  bit           rx_busy = 1'b0;
  int           rx_t    = 0;
  logic [7:0]   rx_sh   = 8'h00;

  always @(negedge iCLK) begin
    if (iRST) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (oTX === 1'b0) begin
        rx_busy = 1'b1;
        rx_t    = 0;
      end
    end else begin
      rx_t++;
      if ((rx_t % CPB) == CPB / 2) begin
        if ((rx_t / CPB) >= 1 && (rx_t / CPB) <= 8) rx_sh[(rx_t / CPB) - 1] = oTX;
        if ((rx_t / CPB) == 9) begin
          rx_q.push_back(rx_sh);
          rx_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- bus tasks (one cycle each) ----------------
  task automatic bus(input bit w, input bit r, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    @(negedge iCLK);
    #1;
    iWriteEnable = w;
    iReadEnable  = r;
    iAddress     = a;
    iWriteData   = d;
    iByteEnable  = be;
  endtask

  task automatic wr(input logic [31:0] offs, input logic [31:0] d);
    bus(1'b1, 1'b0, BASE + offs, d, 4'hF);
  endtask

  task automatic rd(input logic [31:0] offs);
    bus(1'b0, 1'b1, BASE + offs, 32'h0, 4'h0);
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    #1;
    iWriteEnable = 1'b0;
    iReadEnable  = 1'b0;
    iRST         = 1'b1;
    @(negedge iCLK);
    #1;
    iRST = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [9:0] pattern;
    int         n;
    bit         saw_low;
    int         r;

    iRST = 1'b1;
    repeat (2) @(negedge iCLK);
    #1;
    iRST = 1'b0;
    cmp_en = 1'b1;

    // 1: single 0xA5 frame, literal line sequence and busy flag.
    rx_q.delete();
    wr(32'h8, 32'h1);
    wr(32'h0, 32'hA5);
    bus(1'b0, 1'b1, BASE + 32'h4, 32'h0, 4'h0);
    pattern = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge iCLK);
      check("t1_tx_seq", 32'(oTX), 32'(pattern[i / CPB]));
      check("t1_busy", 32'(oReadData[0]), 32'h1);
    end
    @(negedge iCLK);
    check("t1_tx_after", 32'(oTX), 32'h1);
    check("t1_status_after", oReadData, 32'h0000_0004);
    check("t1_rx_count", 32'(rx_q.size()), 32'h1);
    check("t1_rx_byte", 32'(rx_q[0]), 32'hA5);

    // 2: overflow with TXEN=0, then W1C clear.
    wr(32'h8, 32'h0);
    for (int i = 0; i < 9; i++) wr(32'h0, 32'(i));
    rd(32'h4);
    @(negedge iCLK);
    check("t2_status_ovf", oReadData, 32'h0000_080A);
    wr(32'h4, 32'h8);
    rd(32'h4);
    @(negedge iCLK);
    check("t2_status_clr", oReadData, 32'h0000_0802);
    check("t2_tx_idle", 32'(oTX), 32'h1);

    // 3: IRQ on empty FIFO, low during the frame, 41-cycle latency.
    do_reset();
    wr(32'h8, 32'h3);
    idle();
    @(negedge iCLK);
    check("t3_irq_empty", 32'(oIRQ), 32'h1);
    wr(32'h0, 32'h55);
    idle();
    check("t3_irq_low", 32'(oIRQ), 32'h0);
    n = 0;
    while (n < 100) begin
      @(negedge iCLK);
      n++;
      if (oIRQ) break;
    end
    check("t3_irq_latency", 32'(n), 32'(10 * CPB + 1));

    // 4: out-of-window reads and CTRL readback.
    wr(32'h8, 32'h3);
    rd(32'hC);
    @(negedge iCLK);
    check("t4_hit_0xC", 32'(oHit), 32'h0);
    check("t4_rd_0xC", oReadData, 32'h0);
    rd(32'h20);
    @(negedge iCLK);
    check("t4_hit_0x20", 32'(oHit), 32'h0);
    check("t4_rd_0x20", oReadData, 32'h0);
    rd(32'h8);
    @(negedge iCLK);
    check("t4_hit_ctrl", 32'(oHit), 32'h1);
    check("t4_rd_ctrl", oReadData, 32'h0000_0003);
    rd(32'h9);
    @(negedge iCLK);
    check("t4_rd_ctrl_lowbits", oReadData, 32'h0000_0003);

    // 5: reset during DATA bit 3 forces the line high immediately.
    do_reset();
    rx_q.delete();
    wr(32'h8, 32'h1);
    wr(32'h0, 32'h3C);
    wr(32'h0, 32'h81);
    bus(1'b0, 1'b1, BASE + 32'h4, 32'h0, 4'h0);
    n = 0;
    while (oTX !== 1'b0 && n < 20) begin
      @(negedge iCLK);
      n++;
    end
    check("t5_start_seen", 32'(oTX), 32'h0);
    repeat (4 * CPB + 1) @(posedge iCLK);
    #2;
    check("t5_tx_pre", 32'(oTX), 32'(pattern[0] ^ 1'b1 ^ 1'b1) & 32'h0 | 32'(8'h3C >> 3) & 32'h1);
    iRST = 1'b1;
    #1;
    check("t5_tx_async", 32'(oTX), 32'h1);
    check("t5_status_rst", oReadData, 32'h0000_0004);
    repeat (2) @(negedge iCLK);
    #1;
    iRST = 1'b0;
    saw_low = 1'b0;
    repeat (100) begin
      @(negedge iCLK);
      if (oTX !== 1'b1) saw_low = 1'b1;
    end
    check("t5_no_frames", 32'(saw_low), 32'h0);
    check("t5_rx_none", 32'(rx_q.size()), 32'h0);
    check("t5_status_after", oReadData, 32'h0000_0004);

    // 6: push while full coincides with a pop; 0x77 goes out last.
    do_reset();
    rx_q.delete();
    wr(32'h8, 32'h0);
    for (int i = 0; i < DEPTH; i++) wr(32'h0, 32'h10 + 32'(i));
    wr(32'h8, 32'h1);
    wr(32'h0, 32'h77);
    rd(32'h4);
    @(negedge iCLK);
    check("t6_status", oReadData, 32'h0000_0803);
    idle();
    n = 0;
    while (rx_q.size() < DEPTH + 1 && n < 800) begin
      @(negedge iCLK);
      n++;
    end
    check("t6_rx_count", 32'(rx_q.size()), 32'(DEPTH + 1));
    check("t6_rx_first", 32'(rx_q[0]), 32'h10);
    check("t6_rx_last", 32'(rx_q[DEPTH]), 32'h77);

    // Random traffic against the model.
    do_reset();
    repeat (2500) begin
      r = $urandom_range(0, 99);
      if (r < 35)
        bus(1'b1, 1'b0, BASE + 32'($urandom_range(0, 3)), 32'($urandom), 4'($urandom_range(0, 15)));
      else if (r < 42)
        bus(1'b1, 1'b0, BASE + 32'h8, {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)},
            4'($urandom_range(0, 15)));
      else if (r < 47)
        bus(1'b1, 1'b0, BASE + 32'h4, 32'($urandom), 4'hF);
      else if (r < 50)
        bus(1'b1, 1'b0, BASE + 32'hC + 32'($urandom_range(0, 3)), 32'($urandom), 4'hF);
      else if (r < 75)
        bus(1'b0, 1'b1, BASE + 32'($urandom_range(0, 15)), 32'h0, 4'h0);
      else if (r < 80)
        bus($urandom_range(0, 1) == 1, 1'b1, 32'($urandom), 32'($urandom), 4'hF);
      else
        idle();
    end
    idle();
    repeat (4) @(negedge iCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
